reg_file_mp: RTL and testbench

Multi-port, byte-writable general-purpose register file for the RISC-V core; next generation of the single-port `RegFile`. Serves `RD_PORTS` independent registered read ports and one write port with byte enables, same-cycle write-to-read bypass and optional hard-wired zero register. After reset, a sequencer sweeps every entry to zero and only then raises `ready`. It sits between decode (operand reads) and writeback (result writes).

---
 rtl/rf_pkg.sv | 21 ++
 rtl/rf_byte_merge.sv | 31 +++
 rtl/reg_file_mp.sv | 173 +++++++++++++++++
 tb/tb_reg_file_mp.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file.
//   - rf_state_e : sequencer states (RF_CLEAR sweeps the array, RF_RUN serves traffic)
//   - RF_*_W     : default geometry used as parameter defaults by reg_file_mp
//   - rf_ptr_w   : address width needed to index an array of a given depth
package rf_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

  localparam int RF_IDX_W  = 5;
  localparam int RF_DATA_W = 32;
  localparam int RF_BYTE_W = 8;

  // Address width of the storage array; never narrower than one bit.
  function automatic int rf_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rf_byte_merge.sv
// Combinational byte-lane merge.
//   old_word    : current contents
//   new_word    : incoming data
//   be          : byte enables, bit b selects new_word byte b
//   merged_word : old_word with every enabled byte replaced by new_word
// Shared by the array write path and by every read port's bypass path so
// both always agree on what a partial write produces.
module rf_byte_merge #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0]            old_word,
  input  logic [DATA_WIDTH-1:0]            new_word,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be,
  output logic [DATA_WIDTH-1:0]            merged_word
);

  localparam int BE_WIDTH = DATA_WIDTH / BYTE_WIDTH;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no latch is inferred when a byte is not enabled.
  always_comb begin
    merged_word = old_word;
    for (int b = 0; b < BE_WIDTH; b++) begin
      if (be[b]) begin
        merged_word[b*BYTE_WIDTH +: BYTE_WIDTH] = new_word[b*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port, byte-writable register file.
//   sys_clk / sys_rst : rising-edge clock, synchronous active-high reset
//   ready             : high once the post-reset clear sweep has finished
//   rd_en/rd_idx      : per-port read requests, indices packed REG_IDX_WIDTH apart
//   rd_data/rd_valid  : registered read results (1-cycle latency), same packing
//   wr_en/wr_idx/wr_be/wr_data : single write port with byte enables
// Reads see a same-edge write through a per-port bypass. Out-of-range
// indices read as 0 and drop writes; with ZERO_REG, entry 0 behaves the same.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int REG_IDX_WIDTH = RF_IDX_W,
  parameter int DATA_WIDTH    = RF_DATA_W,
  parameter int BYTE_WIDTH    = RF_BYTE_W,
  parameter int REG_COUNT     = 32,
  parameter int RD_PORTS      = 2,
  parameter int ZERO_REG      = 1
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst,
  output logic                              ready,
  input  logic [RD_PORTS-1:0]               rd_en,
  input  logic [RD_PORTS*REG_IDX_WIDTH-1:0] rd_idx,
  output logic [RD_PORTS*DATA_WIDTH-1:0]    rd_data,
  output logic [RD_PORTS-1:0]               rd_valid,
  input  logic                              wr_en,
  input  logic [REG_IDX_WIDTH-1:0]          wr_idx,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]  wr_be,
  input  logic [DATA_WIDTH-1:0]             wr_data
);

  localparam int BE_WIDTH = DATA_WIDTH / BYTE_WIDTH;
  localparam int PTR_W    = rf_ptr_w(REG_COUNT);

  localparam logic [PTR_W-1:0]       LAST_PTR  = PTR_W'(REG_COUNT - 1);
  // One bit wider than an index so the bound REG_COUNT itself is representable.
  localparam logic [REG_IDX_WIDTH:0] COUNT_EXT = (REG_IDX_WIDTH + 1)'(REG_COUNT);
  localparam logic                   ZERO_EN   = (ZERO_REG != 0);

  // --------------------------------------------------------------------------
  // Clear sequencer
  // --------------------------------------------------------------------------
  rf_state_e        state, state_nxt;
  logic [PTR_W-1:0] clr_idx, clr_idx_nxt;

  // NOTE: sequential state is updated with non-blocking '<=' so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= RF_CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    case (state)
      RF_CLEAR: begin
        clr_idx_nxt = clr_idx + PTR_W'(1);
        if (clr_idx == LAST_PTR) begin
          state_nxt   = RF_RUN;
          clr_idx_nxt = '0;
        end
      end
      RF_RUN:   ;
      default:  state_nxt = RF_CLEAR;
    endcase
  end

  // ready is a pure decode of the state flop, so a request is honoured only
  // at an edge where ready was already high.
  assign ready = (state == RF_RUN);

  // --------------------------------------------------------------------------
  // Storage and write port
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [REG_COUNT];

  logic [PTR_W-1:0]      wr_ptr;
  logic                  wr_in_range;
  logic                  wr_zero;
  logic                  wr_do;
  logic [DATA_WIDTH-1:0] wr_old;
  logic [DATA_WIDTH-1:0] wr_merged;

  assign wr_ptr      = wr_idx[PTR_W-1:0];
  assign wr_in_range = ({1'b0, wr_idx} < COUNT_EXT);
  assign wr_zero     = ZERO_EN && (wr_idx == '0);
  assign wr_do       = (state == RF_RUN) && wr_en && wr_in_range && !wr_zero;
  assign wr_old      = mem[wr_ptr];

  rf_byte_merge #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH)
  ) u_wr_merge (
    .old_word    (wr_old),
    .new_word    (wr_data),
    .be          (wr_be),
    .merged_word (wr_merged)
  );

  // NOTE: the array has no reset branch; it is zeroed by the CLEAR sweep so it
  // can map onto plain RAM/flops without a reset net.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      if (state == RF_CLEAR) begin
        mem[clr_idx] <= '0;
      end else if (wr_do) begin
        mem[wr_ptr] <= wr_merged;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [REG_IDX_WIDTH-1:0] idx;
    logic [PTR_W-1:0]         ptr;
    logic                     in_range;
    logic                     zero_hit;
    logic                     byp_hit;
    logic [BE_WIDTH-1:0]      byp_be;
    logic [DATA_WIDTH-1:0]    stored;
    logic [DATA_WIDTH-1:0]    merged;
    logic [DATA_WIDTH-1:0]    value;
    logic                     valid_q;
    logic [DATA_WIDTH-1:0]    data_q;

    assign idx      = rd_idx[p*REG_IDX_WIDTH +: REG_IDX_WIDTH];
    assign ptr      = idx[PTR_W-1:0];
    assign in_range = ({1'b0, idx} < COUNT_EXT);
    assign zero_hit = ZERO_EN && (idx == '0);
    assign stored   = mem[ptr];

    // Bypass only the bytes this edge actually writes; an out-of-range or
    // zero-register hit is masked below, so it never leaks through.
    assign byp_hit  = wr_en && (wr_idx == idx);
    assign byp_be   = byp_hit ? wr_be : '0;

    rf_byte_merge #(
      .DATA_WIDTH (DATA_WIDTH),
      .BYTE_WIDTH (BYTE_WIDTH)
    ) u_byp_merge (
      .old_word    (stored),
      .new_word    (wr_data),
      .be          (byp_be),
      .merged_word (merged)
    );

    assign value = (in_range && !zero_hit) ? merged : '0;

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if ((state == RF_RUN) && rd_en[p]) begin
        valid_q <= 1'b1;
        data_q  <= value;
      end else begin
        valid_q <= 1'b0;
      end
    end

    assign rd_valid[p]                            = valid_q;
    assign rd_data[p*DATA_WIDTH +: DATA_WIDTH]    = data_q;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp. Two instances share clock, reset and
// stimulus: dut (32 entries) and dut16 (REG_COUNT=16) for the out-of-range cases.
module tb_reg_file_mp;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [1:0]  rd_en   = '0;
  logic [9:0]  rd_idx  = '0;
  logic        wr_en   = 1'b0;
  logic [4:0]  wr_idx  = '0;
  logic [3:0]  wr_be   = '0;
  logic [31:0] wr_data = '0;

  logic        ready,    ready16;
  logic [63:0] rd_data,  rd_data16;
  logic [1:0]  rd_valid, rd_valid16;

  int total = 0;
  int bad   = 0;

  always #5 sys_clk = ~sys_clk;

  reg_file_mp #(.REG_COUNT(32)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .ready    (ready),
    .rd_en    (rd_en),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_be    (wr_be),
    .wr_data  (wr_data)
  );

  reg_file_mp #(.REG_COUNT(16)) dut16 (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .ready    (ready16),
    .rd_en    (rd_en),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data16),
    .rd_valid (rd_valid16),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_be    (wr_be),
    .wr_data  (wr_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // One cycle of traffic, then all requests are withdrawn.
  task automatic cyc(input logic we, input logic [4:0] wi, input logic [3:0] be,
                     input logic [31:0] wd, input logic [1:0] re,
                     input logic [4:0] r0, input logic [4:0] r1);
    wr_en   = we;
    wr_idx  = wi;
    wr_be   = be;
    wr_data = wd;
    rd_en   = re;
    rd_idx  = {r1, r0};
    step();
    wr_en = 1'b0;
    rd_en = '0;
  endtask

  function automatic logic [31:0] pat(input int i);
    return (i == 0) ? 32'h0 : i * 32'h01010101;
  endfunction

  function automatic logic [31:0] pat16(input int i);
    return (i >= 16) ? 32'h0 : pat(i);
  endfunction

  task automatic wait_clear(input string tag);
    for (int k = 1; k <= 32; k++) begin
      step();
      if (k == 15 || k == 16) check($sformatf("%s ready16 k=%0d", tag, k), ready16, k == 16);
      if (k == 31 || k == 32) check($sformatf("%s ready k=%0d", tag, k), ready, k == 32);
    end
  endtask

  initial begin
    // Reset then idle
    repeat (3) step();
    check("rst ready",    ready,          0);
    check("rst valid",    rd_valid,       0);
    check("rst data lo",  rd_data[31:0],  0);
    check("rst data hi",  rd_data[63:32], 0);
    sys_rst = 1'b0;
    wait_clear("clr");

    for (int i = 0; i < 32; i += 2) begin
      cyc(0, 0, 0, 0, 2'b11, 5'(i), 5'(i + 1));
      check($sformatf("zero p0 i=%0d", i),     rd_data[31:0],  0);
      check($sformatf("zero p1 i=%0d", i + 1), rd_data[63:32], 0);
    end

    // Full write/read sweep
    for (int i = 1; i < 32; i++) cyc(1, 5'(i), 4'hF, pat(i), 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      cyc(0, 0, 0, 0, 2'b11, 5'(i), 5'(31 - i));
      check($sformatf("sweep valid i=%0d", i),   rd_valid,         2'b11);
      check($sformatf("sweep p0 i=%0d", i),      rd_data[31:0],    pat(i));
      check($sformatf("sweep p1 i=%0d", i),      rd_data[63:32],   pat(31 - i));
      check($sformatf("sweep16 valid i=%0d", i), rd_valid16,       2'b11);
      check($sformatf("sweep16 p0 i=%0d", i),    rd_data16[31:0],  pat16(i));
      check($sformatf("sweep16 p1 i=%0d", i),    rd_data16[63:32], pat16(31 - i));
    end
    // Idle cycle: valid drops, data holds last result (entry 31 / entry 0)
    cyc(0, 0, 0, 0, 2'b00, 0, 0);
    check("idle valid",  rd_valid,       0);
    check("idle hold p0", rd_data[31:0], pat(31));

    // Byte enables
    cyc(1, 5, 4'hF,    32'hAABBCCDD, 0, 0, 0);
    cyc(1, 5, 4'b0101, 32'h11223344, 0, 0, 0);
    cyc(0, 0, 0, 0, 2'b01, 5, 0);
    check("be x5", rd_data[31:0], 32'hAA22CC44);

    // wr_be=0 leaves the entry alone
    cyc(1, 9, 4'h0, 32'hFFFFFFFF, 0, 0, 0);
    cyc(0, 0, 0, 0, 2'b01, 9, 0);
    check("be0 x9", rd_data[31:0], pat(9));

    // Bypass: x7 cleared, then partial write + dual read in the same cycle
    cyc(1, 7, 4'hF, 32'h0, 0, 0, 0);
    cyc(1, 7, 4'b1100, 32'hDEADBEEF, 2'b11, 7, 7);
    check("byp valid", rd_valid,       2'b11);
    check("byp p0",    rd_data[31:0],  32'hDEAD0000);
    check("byp p1",    rd_data[63:32], 32'hDEAD0000);
    cyc(0, 0, 0, 0, 2'b01, 7, 0);
    check("byp stored", rd_data[31:0], 32'hDEAD0000);

    // Zero register, including a same-cycle bypass attempt
    cyc(1, 0, 4'hF, 32'h12345678, 0, 0, 0);
    cyc(1, 0, 4'hF, 32'h12345678, 2'b11, 0, 0);
    check("x0 byp p0", rd_data[31:0],  0);
    check("x0 byp p1", rd_data[63:32], 0);
    cyc(0, 0, 0, 0, 2'b01, 0, 0);
    check("x0 stored", rd_data[31:0], 0);

    // Out of range on the 16-entry instance: index 20 must not alias entry 4
    cyc(1, 20, 4'hF, 32'hCAFEF00D, 0, 0, 0);
    cyc(0, 0, 0, 0, 2'b11, 20, 4);
    check("oor32 p0",     rd_data[31:0],    32'hCAFEF00D);
    check("oor16 valid",  rd_valid16,       2'b11);
    check("oor16 p0",     rd_data16[31:0],  0);
    check("oor16 alias4", rd_data16[63:32], pat(4));

    // Reset mid-run alongside a write and a read of x3
    sys_rst = 1'b1;
    cyc(1, 3, 4'hF, 32'hFFFFFFFF, 2'b11, 3, 3);
    check("mid valid", rd_valid, 0);
    check("mid ready", ready,    0);
    check("mid data",  rd_data[31:0], 0);
    sys_rst = 1'b0;
    // Traffic during CLEAR must be ignored
    wr_en = 1'b1; wr_idx = 3; wr_be = 4'hF; wr_data = 32'h5A5A5A5A;
    rd_en = 2'b11; rd_idx = {5'd3, 5'd3};
    for (int k = 1; k <= 32; k++) begin
      step();
      if (k == 31 || k == 32) check($sformatf("mid ready k=%0d", k), ready, k == 32);
      if (k == 8 || k == 32) check($sformatf("mid clr valid k=%0d", k), rd_valid, 0);
    end
    wr_en = 1'b0;
    rd_en = '0;
    cyc(0, 0, 0, 0, 2'b11, 3, 9);
    check("post x3", rd_data[31:0],  0);
    check("post x9", rd_data[63:32], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
